// File: rtl/seven_segment_scan_decoder.sv
// Receive-side decoder for a multiplexed active-low seven-segment bus.
// Each digit's pattern must hold for STABLE_CYCLES samples before it is decoded to a nibble.
`timescale 1ns/1ps
module seven_segment_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            display,
  input  logic [DIGITS-1:0]     anode,
  output logic [4*DIGITS-1:0]   hex,
  output logic [DIGITS-1:0]     digit_valid,
  output logic [DIGITS-1:0]     error,
  output logic                  frame_valid
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [6:0]          s_disp_q, p_disp_q;
  logic [DIGITS-1:0]   s_an_q, p_an_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                committed_q, committed_d;
  logic [DIGITS-1:0]   seen_q, seen_d, seen_set;
  logic [4*DIGITS-1:0] hex_q, hex_d;
  logic [DIGITS-1:0]   valid_q, valid_d, err_q, err_d;
  logic                frame_q, frame_d;

  logic [DIGITS-1:0]   an_low;
  logic                selected, same, commit;
  logic [IW-1:0]       sel_idx;
  logic [6:0]          pat;
  logic                legal, blank;
  logic [3:0]          nib;

  always_comb begin
    an_low   = ~s_an_q;
    selected = (an_low != '0) && ((an_low & (an_low - DIGITS'(1))) == '0);
    sel_idx  = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (an_low[k]) sel_idx = IW'(k);
    end
    same = (s_disp_q == p_disp_q) && (s_an_q == p_an_q);
  end

  // The committed flag is cleared before the commit test so a fresh sample can commit at once.
  always_comb begin
    cnt_d       = cnt_q;
    committed_d = committed_q;
    commit      = 1'b0;
    if (!selected) begin
      cnt_d       = '0;
      committed_d = 1'b0;
    end else if (same) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d       = CW'(1);
      committed_d = 1'b0;
    end
    if (selected && (cnt_d == CNT_MAX) && !committed_d) begin
      commit      = 1'b1;
      committed_d = 1'b1;
    end
  end

  always_comb begin
    pat   = ~s_disp_q;
    blank = (pat == 7'h00);
    legal = 1'b1;
    nib   = 4'h0;
    case (pat)
      7'h3F: nib = 4'h0;
      7'h06: nib = 4'h1;
      7'h5B: nib = 4'h2;
      7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;
      7'h6D: nib = 4'h5;
      7'h7D: nib = 4'h6;
      7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h6F: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h7C: nib = 4'hB;
      7'h39: nib = 4'hC;
      7'h5E: nib = 4'hD;
      7'h79: nib = 4'hE;
      7'h71: nib = 4'hF;
      default: legal = 1'b0;
    endcase
  end

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic hit;
    assign hit                  = commit && (sel_idx == IW'(gi));
    assign hex_d[4*gi +: 4]     = (hit && legal) ? nib : hex_q[4*gi +: 4];
    assign valid_d[gi]          = hit ? legal : valid_q[gi];
    assign err_d[gi]            = hit ? (!legal && !blank) : err_q[gi];
    assign seen_set[gi]         = seen_q[gi] | hit;
  end

  // The completing commit's own seen bit is dropped along with the rest.
  always_comb begin
    frame_d = commit && (&seen_set);
    seen_d  = frame_d ? '0 : seen_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_disp_q    <= '1;
      s_an_q      <= '1;
      p_disp_q    <= '1;
      p_an_q      <= '1;
      cnt_q       <= '0;
      committed_q <= 1'b0;
      seen_q      <= '0;
      hex_q       <= '0;
      valid_q     <= '0;
      err_q       <= '0;
      frame_q     <= 1'b0;
    end else begin
      s_disp_q    <= display;
      s_an_q      <= anode;
      p_disp_q    <= s_disp_q;
      p_an_q      <= s_an_q;
      cnt_q       <= cnt_d;
      committed_q <= committed_d;
      seen_q      <= seen_d;
      hex_q       <= hex_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      frame_q     <= frame_d;
    end
  end

  assign hex         = hex_q;
  assign digit_valid = valid_q;
  assign error       = err_q;
  assign frame_valid = frame_q;

endmodule
